// File: rtl/hex_disp_pkg.sv
// Shared 7-segment helpers: hex-digit segment table (gfedcba, active-low)
// and the digit-count helper used to size the scan outputs.
package hex_disp_pkg;

  // Packed table listed from index 15 (F) down to index 0.
  localparam logic [15:0][6:0] SEG_CODES = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic int unsigned num_digits(input int unsigned data_w);
    return data_w / 4;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    return SEG_CODES[nib];
  endfunction

endpackage

// File: rtl/hex_scan.sv
// Multiplexed hex display scanner: prescaler, digit index, per-scan value
// snapshot and registered segment/digit-enable outputs.
module hex_scan
  import hex_disp_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_freeze,
  input  logic [DATA_W-1:0]             i_load_val,
  output logic [6:0]                    o_seg,
  output logic [num_digits(DATA_W)-1:0] o_dig_en
);

  localparam int unsigned NDIG  = num_digits(DATA_W);
  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned PRE_W = $clog2(SCAN_DIV);

  logic [PRE_W-1:0]  r_presc;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_snap;

  logic              w_tc;
  logic              w_last;
  logic [3:0]        w_nib;
  logic [NDIG-1:0]   w_dig;

  always_comb begin
    w_tc   = (r_presc == PRE_W'(SCAN_DIV - 1));
    w_last = (r_idx == IDX_W'(NDIG - 1));
    w_nib  = '0;
    w_dig  = '1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib    = r_snap[4*i +: 4];
        w_dig[i] = 1'b0;
      end
    end
  end

  // Snapshot only reloads on the wrap to digit 0, so one scan never mixes registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc  <= '0;
      r_idx    <= '0;
      r_snap   <= '0;
      o_seg    <= SEG_CODES[0];
      o_dig_en <= {{(NDIG-1){1'b1}}, 1'b0};
    end else begin
      o_seg    <= seg_decode(w_nib);
      o_dig_en <= w_dig;
      if (w_tc) begin
        r_presc <= '0;
        if (w_last) begin
          r_idx <= '0;
          if (!i_freeze) r_snap <= i_load_val;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end else begin
        r_presc <= r_presc + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/param_reg_file_hexscan.sv
// Register file (R0 hard-wired to zero, optional write-to-read forwarding)
// with a scanned hex display of one selected register.
module param_reg_file_hexscan
  import hex_disp_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             wdest,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [ADDR_W-1:0]             raddr1,
  input  logic [ADDR_W-1:0]             raddr2,
  output logic [DATA_W-1:0]             rdata1,
  output logic [DATA_W-1:0]             rdata2,
  input  logic [ADDR_W-1:0]             disp_sel,
  input  logic                          disp_freeze,
  output logic [6:0]                    seg,
  output logic [num_digits(DATA_W)-1:0] dig_en
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];

  logic              w_wr;
  logic [ADDR_W-1:0] w_ra [3];
  logic [DATA_W-1:0] w_rd [3];

  // Three identical read ports; the third feeds the display snapshot.
  always_comb begin
    w_wr    = we && (wdest != '0);
    w_ra[0] = raddr1;
    w_ra[1] = raddr2;
    w_ra[2] = disp_sel;
    for (int unsigned p = 0; p < 3; p++) begin
      w_rd[p] = r_regs[w_ra[p]];
      if ((BYPASS != 0) && w_wr && (w_ra[p] == wdest)) w_rd[p] = wdata;
      if (w_ra[p] == '0) w_rd[p] = '0;
    end
    rdata1 = w_rd[0];
    rdata2 = w_rd[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[wdest] <= wdata;
    end
  end

  hex_scan #(
    .DATA_W  (DATA_W),
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .i_freeze  (disp_freeze),
    .i_load_val(w_rd[2]),
    .o_seg     (seg),
    .o_dig_en  (dig_en)
  );

endmodule

// File: tb/tb_param_reg_file_hexscan.sv
// Directed bench for param_reg_file_hexscan: two instances (forwarding on/off),
// expected values queued at drive time and popped at each sample point.
module tb_param_reg_file_hexscan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  wdest = '0;
  logic [15:0] wdata = '0;
  logic [2:0]  raddr1 = '0;
  logic [2:0]  raddr2 = '0;
  logic [2:0]  disp_sel = '0;
  logic        disp_freeze = 1'b0;

  logic [15:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  dig_a, dig_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;
  exp_t sb[$];

  logic [6:0] SEGS [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #10 clk = ~clk;

  param_reg_file_hexscan #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .SCAN_DIV(4)) u_dut_a (
    .clk(clk), .rst(rst), .we(we), .wdest(wdest), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_a), .rdata2(rdata2_a),
    .disp_sel(disp_sel), .disp_freeze(disp_freeze), .seg(seg_a), .dig_en(dig_a)
  );

  param_reg_file_hexscan #(.DATA_W(16), .ADDR_W(3), .BYPASS(0), .SCAN_DIV(4)) u_dut_b (
    .clk(clk), .rst(rst), .we(we), .wdest(wdest), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_b), .rdata2(rdata2_b),
    .disp_sel(disp_sel), .disp_freeze(disp_freeze), .seg(seg_b), .dig_en(dig_b)
  );

  task automatic push(input string tag, input logic [15:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: observed %h, required a queued expectation", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h, required %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_disp(input string tag, input logic [3:0] nib, input int unsigned d);
    logic [3:0] dexp;
    dexp = ~(4'b0001 << d);
    push({tag, "_seg"}, {9'd0, SEGS[nib]});
    check({9'd0, seg_a});
    push({tag, "_dig"}, {12'd0, dexp});
    check({12'd0, dig_a});
  endtask

  // Called at the sample point where digit 0 has just appeared; checks 16 cycles.
  task automatic check_scan(input string tag, input logic [15:0] v,
                            input int unsigned chg_cyc, input logic [2:0] chg_sel);
    for (int unsigned c = 0; c < 16; c++) begin
      int unsigned d;
      logic [15:0] sh;
      d  = c / 4;
      sh = v >> (4 * d);
      check_disp(tag, sh[3:0], d);
      if (c == chg_cyc) disp_sel = chg_sel;
      step();
    end
  endtask

  task automatic wait_wrap();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    step();
    prev = dig_a;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (prev != 4'b1110 && dig_a == 4'b1110) found = 1'b1;
      else prev = dig_a;
    end
    if (!found) begin
      push("wrap_timeout", 16'd1);
      check(16'd0);
    end
  endtask

  initial begin
    // Reset with a simultaneous write to R1: reset must win.
    we = 1'b1; wdest = 3'd1; wdata = 16'hFFFF;
    step();
    step();
    check_disp("reset", 4'h0, 0);
    rst = 1'b0; we = 1'b0;
    for (int a = 0; a < 8; a++) begin
      raddr1 = 3'(a); raddr2 = 3'(a);
      #1;
      push("reset_rd1_a", 16'h0000); check(rdata1_a);
      push("reset_rd2_b", 16'h0000); check(rdata2_b);
    end

    // Plain write then read; write to R0 ignored (and never forwarded).
    we = 1'b1; wdest = 3'd3; wdata = 16'hA5F1;
    step();
    we = 1'b0; raddr1 = 3'd3;
    #1;
    push("r3_rd_a", 16'hA5F1); check(rdata1_a);
    push("r3_rd_b", 16'hA5F1); check(rdata1_b);
    we = 1'b1; wdest = 3'd0; wdata = 16'hFFFF; raddr1 = 3'd0;
    #1;
    push("r0_fwd_a", 16'h0000); check(rdata1_a);
    step();
    we = 1'b0;
    #1;
    push("r0_rd_a", 16'h0000); check(rdata1_a);
    push("r0_rd_b", 16'h0000); check(rdata1_b);

    // Same-cycle forwarding versus old value.
    we = 1'b1; wdest = 3'd2; wdata = 16'h1234; raddr2 = 3'd2;
    #1;
    push("bypass_on", 16'h1234);  check(rdata2_a);
    push("bypass_off", 16'h0000); check(rdata2_b);
    step();
    we = 1'b0;
    #1;
    push("r2_after_a", 16'h1234); check(rdata2_a);
    push("r2_after_b", 16'h1234); check(rdata2_b);

    // Display R5; switch to R2 mid-scan, which must wait for the next wrap.
    we = 1'b1; wdest = 3'd5; wdata = 16'hA5F1; disp_sel = 3'd5;
    step();
    we = 1'b0;
    wait_wrap();
    check_scan("scan_r5", 16'hA5F1, 6, 3'd2);
    check_scan("scan_r2", 16'h1234, 99, 3'd0);

    // Freeze holds the snapshot even after R5 is cleared.
    disp_sel = 3'd5;
    wait_wrap();
    check_scan("pre_frz", 16'hA5F1, 99, 3'd0);
    disp_freeze = 1'b1;
    we = 1'b1; wdest = 3'd5; wdata = 16'h0000;
    step();
    we = 1'b0;
    wait_wrap();
    check_scan("frz1", 16'hA5F1, 99, 3'd0);
    check_scan("frz2", 16'hA5F1, 99, 3'd0);
    disp_freeze = 1'b0;
    wait_wrap();
    check_scan("unfrz", 16'h0000, 99, 3'd0);

    // Reset while digit 2 of R3 (0xA5F1) is being shown.
    disp_sel = 3'd3;
    wait_wrap();
    begin
      logic [3:0] prev;
      bit found;
      found = 1'b0;
      prev = dig_a;
      for (int i = 0; i < 40 && !found; i++) begin
        step();
        if (prev != 4'b1011 && dig_a == 4'b1011) found = 1'b1;
        else prev = dig_a;
      end
      if (!found) begin
        push("idx2_timeout", 16'd1);
        check(16'd0);
      end
    end
    check_disp("pre_rst_d2", 4'h5, 2);
    rst = 1'b1;
    step();
    check_disp("rst_mid", 4'h0, 0);
    rst = 1'b0;
    step();
    check_disp("rst_mid_p1", 4'h0, 0);
    repeat (4) step();
    check_disp("rst_mid_d1", 4'h0, 1);
    raddr1 = 3'd3;
    #1;
    push("rst_r3_cleared", 16'h0000); check(rdata1_a);

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_reg_file_hexscan.md
PARAM_REG_FILE_HEXSCAN -- requirements
Module: param_reg_file_hexscan

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, meaning register width in bits, a multiple of 4.
REQ-002 The module SHALL have parameter ADDR_W, default 3, meaning address width; depth is 2**ADDR_W.
REQ-003 The module SHALL have parameter BYPASS, default 1, meaning write-to-read forwarding is enabled when 1.
REQ-004 The module SHALL have parameter SCAN_DIV, default 50000, meaning clocks per display digit slot, with SCAN_DIV >= 2.
REQ-005 The module SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The module SHALL have port we, input, 1 bit: write enable.
REQ-008 The module SHALL have port wdest, input, ADDR_W bits: write address.
REQ-009 The module SHALL have port wdata, input, DATA_W bits: write data.
REQ-010 The module SHALL have ports raddr1 and raddr2, input, ADDR_W bits each: read addresses.
REQ-011 The module SHALL have ports rdata1 and rdata2, output, DATA_W bits each: read data.
REQ-012 The module SHALL have port disp_sel, input, ADDR_W bits: register to display.
REQ-013 The module SHALL have port disp_freeze, input, 1 bit: hold the current display snapshot.
REQ-014 The module SHALL have port seg, output, 7 bits: segments gfedcba, active-low.
REQ-015 The module SHALL have port dig_en, output, DATA_W/4 bits: digit enables, one-hot active-low; bit i selects nibble i.

Function
REQ-016 Register 0 SHALL always read 0; writes to address 0 SHALL be ignored.
REQ-017 When we=1 and wdest!=0, R[wdest] SHALL take wdata at the rising edge.
REQ-018 Reads SHALL be combinational: rdataN = R[raddrN].
REQ-019 With BYPASS=1, when we=1, wdest!=0 and raddrN==wdest, rdataN SHALL equal wdata in the same cycle; with BYPASS=0 it SHALL return the old value.
REQ-020 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; at its terminal count the digit index SHALL advance by 1, wrapping from DATA_W/4-1 to 0.
REQ-021 When the digit index wraps to 0 and disp_freeze=0, snapshot SHALL load the read value of R[disp_sel], including bypass per REQ-019; with disp_freeze=1 the snapshot SHALL hold.
REQ-022 seg SHALL be the decode of snapshot nibble [digit index], active-low. Codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 dig_en SHALL drive low only the bit equal to the digit index; seg and dig_en SHALL be registered, with one cycle latency from the index/snapshot update.
REQ-024 Changes of disp_sel mid-scan SHALL take effect only at the next wrap to digit 0, so no digit ever shows a mix of two registers within one scan.

Reset
REQ-025 On rst=1 at a rising edge, all registers, the snapshot, the prescaler and the digit index SHALL clear to 0; seg SHALL become 1000000 and dig_en SHALL become all ones except bit 0 = 0.
REQ-026 Reset SHALL take priority over a simultaneous write and over a scan advance.
REQ-027 rst asserted mid-scan SHALL restart the scan at digit 0 on the next cycle.

Structure
REQ-028 The 7-segment code table and the helper function for DATA_W/4 SHALL reside in the shared package hex_disp_pkg.
REQ-029 The digit scan (prescaler, index, snapshot, output registers) SHALL be the sub-module hex_scan, parameterised by DATA_W and SCAN_DIV.

Verification
REQ-030 Test: reset, then read all addresses -> all return 0; seg=1000000; dig_en=...1110.
REQ-031 Test: write R3=0xA5F1, then read raddr1=3 the next cycle -> 0xA5F1; write R0=0xFFFF -> R0 still reads 0.
REQ-032 Test: BYPASS=1, we=1, wdest=2, wdata=0x1234, raddr2=2 in the same cycle -> rdata2=0x1234; with BYPASS=0 -> old value 0.
REQ-033 Test: SCAN_DIV=4, R5=0xA5F1, disp_sel=5 -> after a wrap, digits 0..3 show seg 1111001, 0001110, 0010010, 0001000, each held 4 clocks.
REQ-034 Test: disp_freeze=1, then write R5=0x0000 -> display keeps 0xA5F1 across scans; release freeze -> 0000 appears from the next wrap.
REQ-035 Test: rst pulse while digit index=2 -> next cycle index=0, snapshot=0, seg=1000000.
